// File: rtl/control_sequencer.sv
// control_sequencer
// Instruction control unit. It accepts one instruction word at a time and
// decodes the opcode into one-hot datapath strobes. For memory and
// multi-cycle ALU operations it holds the strobe until the completion
// handshake arrives, or until a bounded wait expires.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   CU_en, ir_valid    acceptance gate and instruction-valid qualifier
//   IR                 instruction word: opcode in the top OPC_W bits
//   ir_ready, busy     idle / instruction-in-flight indicators
//   flags              ALU status (Z=3, N=2, C=1, O=0), sampled in DECODE
//   mem_ack, alu_done  completion handshakes for waiting instructions
//   alu_op             ALU operation code
//   immediate, bra, RD, WR, alu_en, psh, pop, hlt, mov_en
//                      datapath strobes
//   imm_value, BADR    immediate and branch-target fields
//   ir9sel, ir0sel     IR[9] and IR[0]
//   illegal            one-cycle pulse for an unknown opcode
//   timeout_err        sticky flag, set when a wait expires
module control_sequencer #(
    parameter int IR_W     = 16,
    parameter int OPC_W    = 6,
    parameter int IMM_W    = 9,
    parameter int BADR_W   = 10,
    parameter int FLAG_W   = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CU_en,
    input  logic [IR_W-1:0]   IR,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [FLAG_W-1:0] flags,
    input  logic              mem_ack,
    input  logic              alu_done,
    output logic [4:0]        alu_op,
    output logic              immediate,
    output logic              bra,
    output logic              RD,
    output logic              WR,
    output logic              alu_en,
    output logic              psh,
    output logic              pop,
    output logic              hlt,
    output logic              mov_en,
    output logic [IMM_W-1:0]  imm_value,
    output logic              ir9sel,
    output logic              ir0sel,
    output logic [BADR_W-1:0] BADR,
    output logic              busy,
    output logic              illegal,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    // Opcode encodings
    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(6'h00);
    localparam logic [OPC_W-1:0] OP_ADDXY = OPC_W'(6'h01);
    localparam logic [OPC_W-1:0] OP_SUBXY = OPC_W'(6'h02);
    localparam logic [OPC_W-1:0] OP_ANDXY = OPC_W'(6'h03);
    localparam logic [OPC_W-1:0] OP_ORXY  = OPC_W'(6'h04);
    localparam logic [OPC_W-1:0] OP_XORXY = OPC_W'(6'h05);
    localparam logic [OPC_W-1:0] OP_MULXY = OPC_W'(6'h06);
    localparam logic [OPC_W-1:0] OP_DIVXY = OPC_W'(6'h07);
    localparam logic [OPC_W-1:0] OP_MODXY = OPC_W'(6'h08);
    localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(6'h09);
    localparam logic [OPC_W-1:0] OP_DEC   = OPC_W'(6'h0A);
    localparam logic [OPC_W-1:0] OP_ADDRI = OPC_W'(6'h11);
    localparam logic [OPC_W-1:0] OP_SUBRI = OPC_W'(6'h12);
    localparam logic [OPC_W-1:0] OP_ANDRI = OPC_W'(6'h13);
    localparam logic [OPC_W-1:0] OP_ORRI  = OPC_W'(6'h14);
    localparam logic [OPC_W-1:0] OP_XORRI = OPC_W'(6'h15);
    localparam logic [OPC_W-1:0] OP_MULRI = OPC_W'(6'h16);
    localparam logic [OPC_W-1:0] OP_DIVRI = OPC_W'(6'h17);
    localparam logic [OPC_W-1:0] OP_MODRI = OPC_W'(6'h18);
    localparam logic [OPC_W-1:0] OP_MOVR  = OPC_W'(6'h20);
    localparam logic [OPC_W-1:0] OP_MOVI  = OPC_W'(6'h21);
    localparam logic [OPC_W-1:0] OP_LDR   = OPC_W'(6'h24);
    localparam logic [OPC_W-1:0] OP_STR   = OPC_W'(6'h25);
    localparam logic [OPC_W-1:0] OP_PSH   = OPC_W'(6'h26);
    localparam logic [OPC_W-1:0] OP_POP   = OPC_W'(6'h27);
    localparam logic [OPC_W-1:0] OP_BRA   = OPC_W'(6'h28);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(6'h29);
    localparam logic [OPC_W-1:0] OP_RET   = OPC_W'(6'h2A);
    localparam logic [OPC_W-1:0] OP_BRZ   = OPC_W'(6'h2B);
    localparam logic [OPC_W-1:0] OP_BRN   = OPC_W'(6'h2C);
    localparam logic [OPC_W-1:0] OP_BRC   = OPC_W'(6'h2D);
    localparam logic [OPC_W-1:0] OP_BRO   = OPC_W'(6'h2E);
    localparam logic [OPC_W-1:0] OP_HLT   = OPC_W'(6'h30);

    // ALU operation codes
    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_XOR = 5'd5;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;
    localparam logic [4:0] ALU_MOD = 5'd8;
    localparam logic [4:0] ALU_INC = 5'd9;
    localparam logic [4:0] ALU_DEC = 5'd10;

    // Bit positions in the packed strobe register
    localparam int S_BRA = 7;
    localparam int S_RD  = 6;
    localparam int S_WR  = 5;
    localparam int S_ALU = 4;
    localparam int S_PSH = 3;
    localparam int S_POP = 2;
    localparam int S_MOV = 1;
    localparam int S_IMM = 0;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WAIT_MEM, WAIT_ALU, HALT} state_t;

    state_t           state_reg;
    logic [IR_W-1:0]  ir_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       strobe_reg;

    logic [OPC_W-1:0] opcode;
    logic [7:0]       dec_strobe;
    logic [4:0]       dec_alu_op;
    logic             dec_hlt;
    logic             dec_illegal;
    logic             dec_mem_wait;
    logic             dec_alu_wait;
    logic             exec_ack;
    logic             wait_ack;

    assign {bra, RD, WR, alu_en, psh, pop, mov_en, immediate} = strobe_reg;
    assign opcode = ir_reg[IR_W-1 -: OPC_W];

    // The decode reads the latched IR, so it stays stable through EXEC and
    // the waits. The flags term only matters on the DECODE edge.
    always_comb begin
        dec_strobe   = '0;
        dec_alu_op   = ALU_NOP;
        dec_hlt      = 1'b0;
        dec_illegal  = 1'b0;
        dec_mem_wait = 1'b0;
        case (opcode)
            OP_NOP:   ;
            OP_ADDXY: dec_alu_op = ALU_ADD;
            OP_SUBXY: dec_alu_op = ALU_SUB;
            OP_ANDXY: dec_alu_op = ALU_AND;
            OP_ORXY:  dec_alu_op = ALU_OR;
            OP_XORXY: dec_alu_op = ALU_XOR;
            OP_MULXY: dec_alu_op = ALU_MUL;
            OP_DIVXY: dec_alu_op = ALU_DIV;
            OP_MODXY: dec_alu_op = ALU_MOD;
            OP_INC:   dec_alu_op = ALU_INC;
            OP_DEC:   dec_alu_op = ALU_DEC;
            OP_ADDRI: begin dec_alu_op = ALU_ADD; dec_strobe[S_IMM] = 1'b1; end
            OP_SUBRI: begin dec_alu_op = ALU_SUB; dec_strobe[S_IMM] = 1'b1; end
            OP_ANDRI: begin dec_alu_op = ALU_AND; dec_strobe[S_IMM] = 1'b1; end
            OP_ORRI:  begin dec_alu_op = ALU_OR;  dec_strobe[S_IMM] = 1'b1; end
            OP_XORRI: begin dec_alu_op = ALU_XOR; dec_strobe[S_IMM] = 1'b1; end
            OP_MULRI: begin dec_alu_op = ALU_MUL; dec_strobe[S_IMM] = 1'b1; end
            OP_DIVRI: begin dec_alu_op = ALU_DIV; dec_strobe[S_IMM] = 1'b1; end
            OP_MODRI: begin dec_alu_op = ALU_MOD; dec_strobe[S_IMM] = 1'b1; end
            OP_MOVR:  dec_strobe[S_MOV] = 1'b1;
            OP_MOVI:  begin dec_strobe[S_MOV] = 1'b1; dec_strobe[S_IMM] = 1'b1; end
            OP_LDR:   begin dec_strobe[S_RD]  = 1'b1; dec_mem_wait = 1'b1; end
            OP_STR:   begin dec_strobe[S_WR]  = 1'b1; dec_mem_wait = 1'b1; end
            OP_PSH:   begin dec_strobe[S_PSH] = 1'b1; dec_mem_wait = 1'b1; end
            OP_POP:   begin dec_strobe[S_POP] = 1'b1; dec_mem_wait = 1'b1; end
            OP_BRA, OP_JMP, OP_RET: dec_strobe[S_BRA] = 1'b1;
            OP_BRZ:   dec_strobe[S_BRA] = flags[3];
            OP_BRN:   dec_strobe[S_BRA] = flags[2];
            OP_BRC:   dec_strobe[S_BRA] = flags[1];
            OP_BRO:   dec_strobe[S_BRA] = flags[0];
            OP_HLT:   begin dec_strobe[S_BRA] = 1'b1; dec_hlt = 1'b1; end
            default:  dec_illegal = 1'b1;
        endcase
        // Every XY/RI/INC/DEC form carries a non-NOP ALU code
        if (dec_alu_op != ALU_NOP) begin
            dec_strobe[S_ALU] = 1'b1;
        end
        dec_alu_wait = (dec_alu_op == ALU_MUL) || (dec_alu_op == ALU_DIV) ||
                       (dec_alu_op == ALU_MOD);
    end

    assign exec_ack = dec_mem_wait ? mem_ack : alu_done;
    assign wait_ack = (state_reg == WAIT_MEM) ? mem_ack : alu_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ir_reg      <= '0;
            cnt_reg     <= '0;
            strobe_reg  <= '0;
            ir_ready    <= 1'b1;
            busy        <= 1'b0;
            hlt         <= 1'b0;
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
            alu_op      <= ALU_NOP;
            imm_value   <= '0;
            ir9sel      <= 1'b0;
            ir0sel      <= 1'b0;
            BADR        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (CU_en && ir_valid) begin
                        ir_reg    <= IR;
                        state_reg <= DECODE;
                        ir_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DECODE: begin
                    imm_value  <= ir_reg[IMM_W-1:0];
                    BADR       <= ir_reg[BADR_W-1:0];
                    ir9sel     <= ir_reg[9];
                    ir0sel     <= ir_reg[0];
                    alu_op     <= dec_alu_op;
                    strobe_reg <= dec_strobe;
                    hlt        <= dec_hlt;
                    illegal    <= dec_illegal;
                    state_reg  <= EXEC;
                end
                EXEC: begin
                    illegal <= 1'b0;
                    if (dec_hlt) begin
                        // hlt stays set; bra is only a one-cycle redirect
                        strobe_reg <= '0;
                        busy       <= 1'b0;
                        state_reg  <= HALT;
                    end else if ((dec_mem_wait || dec_alu_wait) && !exec_ack) begin
                        cnt_reg   <= '0;
                        state_reg <= dec_mem_wait ? WAIT_MEM : WAIT_ALU;
                    end else begin
                        strobe_reg <= '0;
                        busy       <= 1'b0;
                        ir_ready   <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                WAIT_MEM, WAIT_ALU: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // An ack on the last permitted cycle still wins over timeout
                    if (wait_ack || (cnt_reg == CNT_W'(WAIT_MAX - 1))) begin
                        if (!wait_ack) begin
                            timeout_err <= 1'b1;
                        end
                        strobe_reg <= '0;
                        busy       <= 1'b0;
                        ir_ready   <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                HALT: ;
                default: begin
                    strobe_reg <= '0;
                    busy       <= 1'b0;
                    ir_ready   <= 1'b1;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Randomized and directed stimulus for control_sequencer, checked against a
// behavioural model of the opcode rules and of the wait/timeout timing.
module tb_control_sequencer;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        CU_en = 1'b0;
    logic [15:0] IR = '0;
    logic        ir_valid = 1'b0;
    logic        ir_ready;
    logic [3:0]  flags = '0;
    logic        mem_ack = 1'b0;
    logic        alu_done = 1'b0;
    logic [4:0]  alu_op;
    logic        immediate, bra, RD, WR, alu_en, psh, pop, hlt, mov_en;
    logic [8:0]  imm_value;
    logic        ir9sel, ir0sel;
    logic [9:0]  BADR;
    logic        busy, illegal, timeout_err;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_timeout = 1'b0;

    control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .CU_en(CU_en), .IR(IR), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .flags(flags), .mem_ack(mem_ack), .alu_done(alu_done),
        .alu_op(alu_op), .immediate(immediate), .bra(bra), .RD(RD), .WR(WR),
        .alu_en(alu_en), .psh(psh), .pop(pop), .hlt(hlt), .mov_en(mov_en),
        .imm_value(imm_value), .ir9sel(ir9sel), .ir0sel(ir0sel), .BADR(BADR),
        .busy(busy), .illegal(illegal), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bench strobe order: {bra, RD, WR, psh, pop, alu_en, mov_en, immediate}
    function automatic logic [7:0] strobes_now();
        return {bra, RD, WR, psh, pop, alu_en, mov_en, immediate};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: opcode map -> expected strobes, ALU code, wait kind
    // (0 none, 1 memory, 2 ALU). XY ALU ops occupy 0x01..0x0A with the ALU
    // code equal to the opcode; RI ops mirror them at +0x10.
    task automatic ref_decode(input logic [5:0] opc, input logic [3:0] f,
                              output logic [7:0] stb, output logic hl,
                              output logic ill, output int wk, output logic [4:0] aop);
        int o;
        o   = int'(opc);
        stb = '0;
        hl  = 1'b0;
        ill = 1'b0;
        wk  = 0;
        aop = '0;
        if (o >= 'h01 && o <= 'h0A) begin
            aop = 5'(o);
            stb[2] = 1'b1;
        end else if (o >= 'h11 && o <= 'h18) begin
            aop = 5'(o - 'h10);
            stb[2] = 1'b1;
            stb[0] = 1'b1;
        end else if (o == 'h20) begin
            stb[1] = 1'b1;
        end else if (o == 'h21) begin
            stb[1] = 1'b1;
            stb[0] = 1'b1;
        end else if (o >= 'h24 && o <= 'h27) begin
            stb[6 - (o - 'h24)] = 1'b1;
            wk = 1;
        end else if (o >= 'h28 && o <= 'h2A) begin
            stb[7] = 1'b1;
        end else if (o >= 'h2B && o <= 'h2E) begin
            stb[7] = f[3 - (o - 'h2B)];
        end else if (o == 'h30) begin
            stb[7] = 1'b1;
            hl = 1'b1;
        end else if (o != 'h00) begin
            ill = 1'b1;
        end
        if (aop >= 5'd6 && aop <= 5'd8) wk = 2;
    endtask

    // Runs one non-halting instruction. k is the cycle (EXEC = 0) on which
    // the completion handshake is raised; negative means never.
    task automatic run_instr(input logic [5:0] opc, input logic [9:0] low,
                             input logic [3:0] f, input int k);
        logic [7:0] es;
        logic       eh, ei, to;
        int         wk, hold, n;
        logic [4:0] ea;
        ref_decode(opc, f, es, eh, ei, wk, ea);
        to = 1'b0;
        if (wk == 0) hold = 1;
        else if (k >= 0 && k <= WAIT_MAX) hold = k + 1;
        else begin
            hold = WAIT_MAX + 1;
            to   = 1'b1;
        end
        n = 0;
        while (!ir_ready && n < 50) begin
            tick();
            n++;
        end
        check_value("ready_before", ir_ready, 1);
        $display("instr opc=%02h low=%03h flags=%b ack_cycle=%0d", opc, low, f, k);
        IR = {opc, low};
        ir_valid = 1'b1;
        CU_en = 1'b1;
        tick();                                 // accept edge: now DECODE
        check_value("decode_busy", busy, 1);
        check_value("decode_ready", ir_ready, 0);
        ir_valid = 1'b0;
        CU_en = 1'($urandom_range(0, 1));
        IR = 16'($urandom);
        flags = f;
        tick();                                 // DECODE edge: now EXEC
        flags = 4'($urandom);
        check_value("exec_alu_op", alu_op, ea);
        check_value("exec_imm", imm_value, low[8:0]);
        check_value("exec_badr", BADR, low);
        check_value("exec_ir9", ir9sel, low[9]);
        check_value("exec_ir0", ir0sel, low[0]);
        check_value("exec_hlt", hlt, eh);
        for (int c = 0; c <= hold; c++) begin
            if (c > 0) tick();
            if (c < hold) begin
                check_value("strobes", strobes_now(), es);
                check_value("busy", busy, 1);
                check_value("ready_busy", ir_ready, 0);
                check_value("illegal", illegal, (c == 0) ? ei : 1'b0);
            end else begin
                check_value("idle_ready", ir_ready, 1);
                check_value("idle_busy", busy, 0);
                check_value("idle_strobes", strobes_now(), 0);
                check_value("timeout_err", timeout_err, exp_timeout | to);
                check_value("held_alu_op", alu_op, ea);
                check_value("held_imm", imm_value, low[8:0]);
            end
            mem_ack  = (wk == 1) ? (c == k) : 1'($urandom_range(0, 1));
            alu_done = (wk == 2) ? (c == k) : 1'($urandom_range(0, 1));
        end
        exp_timeout = exp_timeout | to;
        mem_ack  = 1'b0;
        alu_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_value("rst_ready", ir_ready, 1);
        check_value("rst_busy", busy, 0);
        check_value("rst_strobes", strobes_now(), 0);
        check_value("rst_hlt", hlt, 0);
        check_value("rst_illegal", illegal, 0);
        check_value("rst_timeout", timeout_err, 0);
        check_value("rst_alu_op", alu_op, 0);
        check_value("rst_imm", imm_value, 0);
        check_value("rst_badr", BADR, 0);
        // Held in reset across an edge with a valid instruction offered
        IR = {6'h01, 10'h0};
        ir_valid = 1'b1;
        CU_en = 1'b1;
        tick();
        check_value("rst_hold_ready", ir_ready, 1);
        ir_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_value("noval_ready", ir_ready, 1);
        // ir_valid without CU_en must not be accepted
        CU_en = 1'b0;
        ir_valid = 1'b1;
        tick();
        check_value("nocu_ready", ir_ready, 1);
        ir_valid = 1'b0;

        run_instr(6'h11, 10'h005, 4'($urandom), -1);    // ADDRI #5
        run_instr(6'h2B, 10'h155, 4'b1000, -1);          // BRZ taken
        run_instr(6'h2B, 10'h2AA, 4'b0000, -1);          // BRZ not taken
        run_instr(6'h24, 10'h3C1, 4'($urandom), 3);      // LDR, ack 3 after EXEC
        run_instr(6'h07, 10'h000, 4'($urandom), -1);     // DIVXY timeout
        run_instr(6'h3F, 10'h1FF, 4'($urandom), -1);     // undefined opcode

        // Reset while waiting on memory drops the strobe at once
        IR = {6'h24, 10'h0};
        ir_valid = 1'b1;
        CU_en = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        tick();
        check_value("wait_rd", RD, 1);
        #2 rst = 1'b0;
        #1;
        check_value("async_rd", RD, 0);
        check_value("async_busy", busy, 0);
        check_value("async_ready", ir_ready, 1);
        check_value("async_timeout", timeout_err, 0);
        exp_timeout = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 160; i++) begin
            logic [5:0] opc;
            int         k;
            opc = 6'($urandom_range(0, 63));
            if (opc == 6'h30) opc = 6'h16;
            k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, WAIT_MAX + 2));
            run_instr(opc, 10'($urandom), 4'($urandom), k);
        end

        // HLT, then an offered ADDXY that must be ignored
        $display("instr opc=30 (HLT) followed by ADDXY offers");
        IR = {6'h30, 10'h0};
        ir_valid = 1'b1;
        CU_en = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        check_value("hlt_exec_strobes", strobes_now(), 8'h80);
        check_value("hlt_exec_hlt", hlt, 1);
        tick();
        check_value("halt_hlt", hlt, 1);
        check_value("halt_strobes", strobes_now(), 0);
        check_value("halt_busy", busy, 0);
        check_value("halt_ready", ir_ready, 0);
        IR = {6'h01, 10'h0};
        ir_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("halt_hold_hlt", hlt, 1);
            check_value("halt_alu_en", alu_en, 0);
        end
        #2 rst = 1'b0;
        #1;
        check_value("halt_rst_hlt", hlt, 0);
        check_value("halt_rst_ready", ir_ready, 1);
        ir_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
